// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller states,
// default operand width and the iteration counter width.
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // One extra bit so the counter can hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_addshift_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper half,
// then shift the whole accumulator right with the add carry entering at the MSB.
module mul_addshift_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   ma,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential multiplier controller: magnitude shift-add over WIDTH iterations,
// sign fix-up, then result on hi/lo with a start/busy/done handshake.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only on edges where busy=0 (state IDLE); a,b and
  // signed_op are captured on that same edge. done pulses for one cycle and hi/lo
  // are valid from that cycle until the next result or reset.

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_step, acc_fixed;
  logic [WIDTH-1:0]   ma;
  logic               neg;
  logic               sign_on;

  assign sign_on   = (SIGNED_EN != 0) && signed_op;
  assign acc_fixed = neg ? -acc : acc;
  assign state_dbg = state;

  mul_addshift_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .ma       (ma),
    .acc_next (acc_step)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_ITER;
      ST_ITER: if (count == CW'(WIDTH - 1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      acc   <= '0;
      ma    <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // The most negative value negates to itself, which read unsigned is its magnitude.
            ma    <= (sign_on && a[WIDTH-1]) ? -a : a;
            acc   <= {{WIDTH{1'b0}}, ((sign_on && b[WIDTH-1]) ? -b : b)};
            neg   <= sign_on && (a[WIDTH-1] ^ b[WIDTH-1]);
            count <= '0;
            busy  <= 1'b1;
          end
        end
        ST_ITER: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        ST_FIX: begin
          {hi, lo} <= acc_fixed;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: cycle-level reference model of the handshake plus
// directed operations with literal expected products.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  mult_seq_ctrl #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input bit s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = $signed({{W{x[W-1]}}, x});
      sy = $signed({{W{y[W-1]}}, y});
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // ---------------- reference model ----------------
  // Accept start when idle, stay busy WIDTH+1 cycles, then show the product with a done pulse.
  logic        m_busy, m_done;
  int          m_rem;
  logic [63:0] m_prod, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_prod <= '0;
      m_out  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_out  <= m_prod;
        end
        m_rem <= m_rem - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_rem  <= W + 1;
        m_prod <= ref_product(a, b, signed_op);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, busy}, {63'b0, m_busy});
      check("done", {63'b0, done}, {63'b0, m_done});
      check("hi_lo", {hi, lo}, m_out);
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input bit ts, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                       input int glitch_edge, input bit hold);
    int edges;
    int busy_cyc;
    start     = 1'b1;
    a         = ta;
    b         = tb_v;
    signed_op = ts;
    edges     = 0;
    busy_cyc  = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1 && !hold) start = 1'b0;
      if (glitch_edge != 0 && edges == glitch_edge) begin
        start = 1'b1;
        a     = 32'd9;
      end else if (glitch_edge != 0 && edges == glitch_edge + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
    end while (!done && edges < 100);
    if (!done) begin
      check({name, "_timeout"}, 64'(edges), 64'd34);
    end else begin
      check({name, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
      check({name, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
      check({name, "_latency"}, 64'(edges - 1), 64'(W + 1));
      check({name, "_busy_cycles"}, 64'(busy_cyc), 64'(W + 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hi_lo", {hi, lo}, 64'd0);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);

    // model pinned against hand-computed products
    check("model_m7x6", ref_product(32'hFFFF_FFF9, 32'd6, 1'b1), 64'hFFFF_FFFF_FFFF_FFD6);
    check("model_ffxff_u", ref_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0),
          64'hFFFF_FFFE_0000_0001);

    do_op("t1_3x5", 32'd3, 32'd5, 1'b0, 32'h0, 32'h0000_000F, 0, 1'b0);
    do_op("t2_ff_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1, 0, 1'b0);
    do_op("t2_ff_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1, 0, 1'b0);
    do_op("t3_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 0, 1'b0);
    do_op("t3_m7x6", 32'hFFFF_FFF9, 32'd6, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 1'b0);
    do_op("t3_minx1", 32'h8000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    do_op("t3_zero", 32'd0, 32'h1234_5678, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk);
    do_op("t4_glitch", 32'd3, 32'd5, 1'b0, 32'h0, 32'd15, 11, 1'b0);
    repeat (2) @(negedge clk);

    // reset in the middle of an operation
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {63'b0, busy}, 64'd0);
    check("t5_rst_done", {63'b0, done}, 64'd0);
    check("t5_rst_hi_lo", {hi, lo}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_op("t5_2x2", 32'd2, 32'd2, 1'b0, 32'h0, 32'd4, 0, 1'b0);

    // back-to-back: start held through the done cycle
    do_op("t6_first", 32'd3, 32'd5, 1'b0, 32'h0, 32'd15, 0, 1'b1);
    do_op("t6_4x4", 32'd4, 32'd4, 1'b0, 32'h0, 32'd16, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
